// File: rtl/traffic_sensor_cond.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sensor_lane / traffic_sensor_cond
// Brief    : Loop-detector conditioner for the two-road traffic-light
//            controller. Synchronizes raw sensors, debounces arrivals,
//            lingers on departures and masks stuck sensors.
// Revision : 1.0 - initial release
// ============================================================================

// One lane: debounce/linger FSM plus stuck-sensor detector.
module traffic_sensor_lane #(
  parameter int DEBOUNCE  = 4,
  parameter int HOLD      = 8,
  parameter int STUCK_LIM = 600
) (
  input  logic clk,
  input  logic reset,
  input  logic i_s2,
  input  logic i_tick,
  input  logic i_clear_stuck,
  output logic o_pres,
  output logic o_stuck
);

  // One counter serves both the confirm and the linger phases.
  localparam int c_DW = $clog2((DEBOUNCE > HOLD) ? DEBOUNCE : HOLD) + 1;
  localparam int c_SW = $clog2(STUCK_LIM) + 1;

  localparam logic [c_DW-1:0] c_DEB  = c_DW'(DEBOUNCE);
  localparam logic [c_DW-1:0] c_HOLD = c_DW'(HOLD);
  localparam logic [c_SW-1:0] c_SLIM = c_SW'(STUCK_LIM);

  typedef enum logic [1:0] {
    ABSENT  = 2'd0,
    CONFIRM = 2'd1,
    PRESENT = 2'd2,
    LINGER  = 2'd3
  } lane_state_t;

  lane_state_t     r_state;
  lane_state_t     w_state_nxt;
  logic [c_DW-1:0] r_dcnt;
  logic [c_DW-1:0] w_dcnt_nxt;
  logic [c_DW-1:0] w_dcnt_inc;
  logic [c_SW-1:0] r_scnt;
  logic [c_SW-1:0] w_scnt_nxt;
  logic [c_SW-1:0] w_scnt_inc;
  logic            r_stuck;
  logic            w_stuck_nxt;
  logic            r_pres;

  assign w_dcnt_inc = r_dcnt + 1'b1;
  assign w_scnt_inc = r_scnt + 1'b1;

  // Presence FSM: a level change of s2 always wins over a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      ABSENT: begin
        if (i_s2) begin
          w_state_nxt = CONFIRM;
          w_dcnt_nxt  = '0;
        end
      end
      CONFIRM: begin
        if (!i_s2) begin
          w_state_nxt = ABSENT;
          w_dcnt_nxt  = '0;
        end else if (i_tick) begin
          if (w_dcnt_inc == c_DEB) begin
            w_state_nxt = PRESENT;
            w_dcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt  = w_dcnt_inc;
          end
        end
      end
      PRESENT: begin
        if (!i_s2) begin
          w_state_nxt = LINGER;
          w_dcnt_nxt  = '0;
        end
      end
      LINGER: begin
        if (i_s2) begin
          w_state_nxt = PRESENT;
          w_dcnt_nxt  = '0;
        end else if (i_tick) begin
          if (w_dcnt_inc == c_HOLD) begin
            w_state_nxt = ABSENT;
            w_dcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt  = w_dcnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ABSENT;
        w_dcnt_nxt  = '0;
      end
    endcase
  end

  // Stuck detector: counts high ticks, saturates at the limit, clear wins.
  always_comb begin
    w_scnt_nxt  = r_scnt;
    w_stuck_nxt = r_stuck;
    if (i_clear_stuck) begin
      w_scnt_nxt  = '0;
      w_stuck_nxt = 1'b0;
    end else if (!i_s2) begin
      w_scnt_nxt  = '0;
    end else if (i_tick && (r_scnt != c_SLIM)) begin
      w_scnt_nxt = w_scnt_inc;
      if (w_scnt_inc == c_SLIM) begin
        w_stuck_nxt = 1'b1;
      end
    end
  end

  // Lane registers; output is derived from next state so it moves with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ABSENT;
      r_dcnt  <= '0;
      r_scnt  <= '0;
      r_stuck <= 1'b0;
      r_pres  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_scnt  <= w_scnt_nxt;
      r_stuck <= w_stuck_nxt;
      r_pres  <= ((w_state_nxt == PRESENT) || (w_state_nxt == LINGER)) && !w_stuck_nxt;
    end
  end

  assign o_pres  = r_pres;
  assign o_stuck = r_stuck;

endmodule

// Top: shared synchronizers and tick generator feeding two identical lanes.
module traffic_sensor_cond #(
  parameter int TICK_DIV  = 50000,
  parameter int DEBOUNCE  = 4,
  parameter int HOLD      = 8,
  parameter int STUCK_LIM = 600
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  input  logic clear_stuck,
  output logic ta,
  output logic tb,
  output logic stuck_a,
  output logic stuck_b
);

  localparam int              c_TW    = $clog2(TICK_DIV) + 1;
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TICK_DIV - 1);

  logic            r_s1_a;
  logic            r_s2_a;
  logic            r_s1_b;
  logic            r_s2_b;
  logic [c_TW-1:0] r_tcnt;
  logic            w_tick;

  // Two-flop synchronizers for the asynchronous loop detectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_a <= 1'b0;
      r_s2_a <= 1'b0;
      r_s1_b <= 1'b0;
      r_s2_b <= 1'b0;
    end else begin
      r_s1_a <= raw_a;
      r_s2_a <= r_s1_a;
      r_s1_b <= raw_b;
      r_s2_b <= r_s1_b;
    end
  end

  // Free-running tick divider; tick is high on the last count of each period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (r_tcnt == c_TLAST) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_tick = (r_tcnt == c_TLAST);

  traffic_sensor_lane #(
    .DEBOUNCE  (DEBOUNCE),
    .HOLD      (HOLD),
    .STUCK_LIM (STUCK_LIM)
  ) u_lane_a (
    .clk           (clk),
    .reset         (reset),
    .i_s2          (r_s2_a),
    .i_tick        (w_tick),
    .i_clear_stuck (clear_stuck),
    .o_pres        (ta),
    .o_stuck       (stuck_a)
  );

  traffic_sensor_lane #(
    .DEBOUNCE  (DEBOUNCE),
    .HOLD      (HOLD),
    .STUCK_LIM (STUCK_LIM)
  ) u_lane_b (
    .clk           (clk),
    .reset         (reset),
    .i_s2          (r_s2_b),
    .i_tick        (w_tick),
    .i_clear_stuck (clear_stuck),
    .o_pres        (tb),
    .o_stuck       (stuck_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sensor_cond
// Brief    : Self-checking bench for traffic_sensor_cond with small tick
//            parameters; expected windows are queued as stimulus is applied
//            and popped when the watched output event occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_sensor_cond;

  localparam int TICK_DIV  = 4;
  localparam int DEBOUNCE  = 3;
  localparam int HOLD      = 2;
  localparam int STUCK_LIM = 10;

  logic clk = 1'b0;
  logic reset;
  logic raw_a;
  logic raw_b;
  logic clear_stuck;
  logic ta;
  logic tb;
  logic stuck_a;
  logic stuck_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    lo;
    int    hi;
  } exp_t;

  exp_t sb[$];

  traffic_sensor_cond #(
    .TICK_DIV  (TICK_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .HOLD      (HOLD),
    .STUCK_LIM (STUCK_LIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_a       (raw_a),
    .raw_b       (raw_b),
    .clear_stuck (clear_stuck),
    .ta          (ta),
    .tb          (tb),
    .stuck_a     (stuck_a),
    .stuck_b     (stuck_b)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   cnt;
    reset = 1'b1; raw_a = 1'b1; raw_b = 1'b1; clear_stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      sb.push_back('{"reset_outputs", 0, 0});
      e = sb.pop_front();
      n_checks++;
      if (int'({ta, tb, stuck_a, stuck_b}) < e.lo || int'({ta, tb, stuck_a, stuck_b}) > e.hi) begin
        n_fail++;
        $display("FAIL %s: got %b, want 0000", e.tag, {ta, tb, stuck_a, stuck_b});
      end
    end
    // Release: the cycle right after release is cycle 1 of the tick period.
    sb.push_back('{"tick_first", TICK_DIV, TICK_DIV});
    reset = 1'b0; raw_a = 1'b0; raw_b = 1'b0;
    cnt = 99;
    for (int i = 1; i <= 8; i++) begin
      if (dut.w_tick === 1'b1) begin cnt = i; break; end
      step();
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      n_fail++;
      $display("FAIL %s: tick first seen in cycle %0d, want %0d", e.tag, cnt, e.lo);
    end
  endtask

  task automatic test_clean_arrival();
    exp_t e;
    int   cnt;
    int   tb_hi;
    tb_hi = 0;
    sb.push_back('{"arrival_ta_rise", 11, 15});
    raw_a = 1'b1;
    cnt = 99;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (tb !== 1'b0) tb_hi++;
      if (ta === 1'b1) begin cnt = i; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      n_fail++;
      $display("FAIL %s: ta rose after %0d cycles, want %0d..%0d", e.tag, cnt, e.lo, e.hi);
    end
    n_checks++;
    if (tb_hi !== 0) begin
      n_fail++;
      $display("FAIL arrival_tb_quiet: tb high in %0d cycles, want 0", tb_hi);
    end
  endtask

  task automatic test_linger();
    exp_t e;
    int   cnt;
    int   gaps;
    // Drop: presence is held for HOLD ticks.
    sb.push_back('{"linger_hold", 5, 11});
    raw_a = 1'b0;
    cnt = 99;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ta === 1'b0) begin cnt = i; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      n_fail++;
      $display("FAIL %s: ta fell after %0d cycles, want %0d..%0d", e.tag, cnt, e.lo, e.hi);
    end
    // Re-arrive, then re-raise during LINGER: no gap on ta.
    raw_a = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ta === 1'b1) break;
    end
    raw_a = 1'b0;
    repeat (4) step();
    raw_a = 1'b1;
    sb.push_back('{"linger_reraise_gaps", 0, 0});
    gaps = (ta === 1'b1) ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ta !== 1'b1) gaps++;
    end
    e = sb.pop_front();
    n_checks++;
    if (gaps < e.lo || gaps > e.hi) begin
      n_fail++;
      $display("FAIL %s: ta low in %0d cycles, want 0", e.tag, gaps);
    end
    raw_a = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ta === 1'b0) break;
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    int   ta_hi;
    int   tb_hi;
    ta_hi = 0;
    tb_hi = 0;
    sb.push_back('{"bounce_ta_rises", 0, 0});
    for (int r = 0; r < 6; r++) begin
      raw_a = 1'b1;
      for (int i = 0; i < 6; i++) begin step(); if (ta !== 1'b0) ta_hi++; end
      raw_a = 1'b0;
      step();
      if (ta !== 1'b0) ta_hi++;
    end
    for (int i = 0; i < 6; i++) begin step(); if (ta !== 1'b0) ta_hi++; end
    e = sb.pop_front();
    n_checks++;
    if (ta_hi < e.lo || ta_hi > e.hi) begin
      n_fail++;
      $display("FAIL %s: ta high in %0d cycles, want 0", e.tag, ta_hi);
    end
    sb.push_back('{"glitch_tb_rises", 0, 0});
    raw_b = 1'b1;
    step();
    raw_b = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (tb !== 1'b0) tb_hi++; end
    e = sb.pop_front();
    n_checks++;
    if (tb_hi < e.lo || tb_hi > e.hi) begin
      n_fail++;
      $display("FAIL %s: tb high in %0d cycles, want 0", e.tag, tb_hi);
    end
  endtask

  task automatic test_stuck();
    exp_t e;
    int   cnt;
    logic tb_prev;
    logic tb_at;
    sb.push_back('{"stuck_tb_rise", 11, 15});
    raw_b = 1'b1;
    cnt = 99;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (tb === 1'b1) begin cnt = i; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      n_fail++;
      $display("FAIL %s: tb rose after %0d cycles, want %0d..%0d", e.tag, cnt, e.lo, e.hi);
    end
    // Counting from the raw_b rise: STUCK_LIM high ticks land at 39..42.
    sb.push_back('{"stuck_set_time", 37 - cnt, 44 - cnt});
    tb_prev = tb;
    tb_at   = 1'bx;
    cnt = 99;
    for (int i = 1; i <= 60; i++) begin
      tb_prev = tb;
      step();
      if (stuck_b === 1'b1) begin cnt = i; tb_at = tb; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      n_fail++;
      $display("FAIL %s: stuck_b set after %0d more cycles, want %0d..%0d", e.tag, cnt, e.lo, e.hi);
    end
    n_checks++;
    if ({tb_prev, tb_at} !== 2'b10) begin
      n_fail++;
      $display("FAIL stuck_tb_mask: tb before/at set %b%b, want 10", tb_prev, tb_at);
    end
    // Clear: flag drops and presence returns on the same edge.
    repeat (3) step();
    clear_stuck = 1'b1;
    step();
    clear_stuck = 1'b0;
    n_checks++;
    if ({stuck_b, tb, stuck_a} !== 3'b010) begin
      n_fail++;
      $display("FAIL stuck_clear: {stuck_b,tb,stuck_a}=%b, want 010", {stuck_b, tb, stuck_a});
    end
    sb.push_back('{"stuck_reset_time", 37, 40});
    cnt = 99;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (stuck_b === 1'b1) begin cnt = i; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi || tb !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: stuck_b re-set after %0d cycles (tb=%b), want %0d..%0d with tb=0",
               e.tag, cnt, tb, e.lo, e.hi);
    end
    // Sticky even after the sensor goes quiet.
    raw_b = 1'b0;
    repeat (8) step();
    n_checks++;
    if ({stuck_b, tb} !== 2'b10) begin
      n_fail++;
      $display("FAIL stuck_sticky: {stuck_b,tb}=%b, want 10", {stuck_b, tb});
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   cnt;
    raw_a = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (stuck_a === 1'b1) break;
    end
    n_checks++;
    if (stuck_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: stuck_a=%b, want 1", stuck_a);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({ta, tb, stuck_a, stuck_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, want 0000", {ta, tb, stuck_a, stuck_b});
    end
    sb.push_back('{"midreset_reconfirm", 11, 15});
    cnt = 99;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ta === 1'b1) begin cnt = i; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (cnt < e.lo || cnt > e.hi) begin
      n_fail++;
      $display("FAIL %s: ta rose after %0d cycles, want %0d..%0d", e.tag, cnt, e.lo, e.hi);
    end
    raw_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_arrival();
    test_linger();
    test_bounce();
    test_stuck();
    test_mid_reset();
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
